blob_centroid: RTL and testbench
================================

Name: blob_centroid

Overview:
- Sits directly downstream of the binary/median stage and consumes its registered output stream: clk_out_enable, frame_out_enable and pixel_out_color.
- Per frame, it accumulates the pixel count, coordinate sums and bounding box of foreground pixels.
- In the frame blanking interval it runs a sequential divider and publishes the target centroid and bounding box with a one-cycle valid pulse.
- The results feed the tracking/TX logic.

Parameters:
- H_ACTIVE, 640, active pixels per line.
- V_ACTIVE, 480, active lines per frame.
- MIN_PIXELS, 16, minimum foreground count for target_found=1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- clk_enable  in  1  pixel qualifier, from upstream clk_out_enable.
- frame_enable  in  1  high during frame, from upstream frame_out_enable.
- pixel_color  in  16  binary pixel; foreground when nonzero.
- centroid_x  out  10  floor(sum_x/count).
- centroid_y  out  10  floor(sum_y/count).
- bbox_x_min  out  10  leftmost foreground x.
- bbox_x_max  out  10  rightmost foreground x.
- bbox_y_min  out  10  topmost foreground y.
- bbox_y_max  out  10  bottom foreground y.
- pixel_count  out  19  foreground pixels in last frame.
- target_found  out  1  last frame count >= MIN_PIXELS.
- result_valid  out  1  one-cycle pulse: outputs updated.
- busy  out  1  divider running.
- overrun  out  1  one-cycle pulse: frame started before divide finished.

Behaviour:
- Clocking and reset:
  - One clock, clk. rst_n is asynchronous, active-low.
  - All state clears on reset. State machine goes to IDLE.
  - On reset, all outputs are 0. Exception: bbox_x_min and bbox_y_min reset to 10'h3FF.
- Position counters:
  - x and y clear while frame_enable=0.
  - On each clk_enable=1: x increments. At x=H_ACTIVE-1, x wraps to 0 and y increments.
  - y saturates at V_ACTIVE.
  - A pixel is accumulated only if clk_enable=1, frame_enable=1, y<V_ACTIVE and pixel_color!=0.
- Accumulators:
  - count is 19 bits.
  - sum_x and sum_y are 28 bits each. No overflow is possible at 640x480.
  - The bbox min/max registers compare against the current x and y.
- Frame edges: detected from a one-cycle-delayed copy of frame_enable.
  - Rising edge: clears the accumulators. bbox min regs go to 3FF, max regs go to 0. State goes to ACCUM.
  - Falling edge: accumulators freeze.
- State machine: IDLE -> ACCUM -> DIV_X -> DIV_Y -> DONE -> IDLE.
  - ACCUM: accumulates pixels. On frame_enable falling:
    - If count=0: go directly to DONE.
    - Otherwise: go to DIV_X and load the divider with sum_x / count.
  - DIV_X: restoring divider, 28-bit dividend, 19-bit divisor, one quotient bit per cycle, 28 cycles. Then load sum_y and go to DIV_Y.
  - DIV_Y: same 28 cycles. Then go to DONE.
  - DONE, one cycle:
    - Register pixel_count and the bbox values.
    - Register centroid_x and centroid_y as quotient[9:0]. Skip this when count=0; the centroid then holds its previous value.
    - target_found = (count >= MIN_PIXELS).
    - result_valid pulses for this cycle. Then go to IDLE.
- busy is 1 in DIV_X, DIV_Y and DONE.
- Latency: let cycle F be the first clk edge that samples frame_enable=0 after it was 1.
  - count>0: result_valid=1 at F+57.
  - count=0: result_valid=1 at F+1.
- Rising edge of frame_enable while in DIV_X, DIV_Y or DONE:
  - Abort the divide and pulse overrun for one cycle.
  - Outputs keep their previous values; result_valid does not pulse.
  - Accumulators clear and the block enters ACCUM for the new frame.
- Output holding: outputs hold between result_valid pulses. When count=0, the bbox outputs publish 3FF/0/3FF/0.
- clk_enable=0 cycles during the frame: no accumulation, counters hold.
- Reset asserted mid-frame or mid-divide: immediate clear. The partial frame is discarded, and the next rising frame_enable starts cleanly.

Test Plan:
- MIN_PIXELS=1; a single nonzero pixel at (100,50); frame ends -> result_valid at F+57, centroid (100,50), bbox 100..100/50..50, pixel_count=1, target_found=1.
- 10x10 white square at x 200..209, y 100..109 -> pixel_count=100, centroid (204,104) (floor of 204.5), bbox 200..209/100..109, target_found=1.
- All-black frame -> result_valid at F+1, pixel_count=0, target_found=0, centroid unchanged from previous frame, bbox 3FF/0/3FF/0.
- All-white 640x480 frame -> pixel_count=307200, centroid (319,239), bbox 0..639/0..479; extra clk_enable pulses past y=480 are not counted.
- frame_enable re-asserted 20 cycles after a falling edge with count>0 -> overrun pulse, no result_valid, outputs hold; the next frame produces a correct result.
- rst_n low for 3 cycles mid-ACCUM, then a full 4-pixel frame -> outputs 0 during reset, next result reflects only the post-reset frame (count=4).

Source files
------------

// File: rtl/blob_centroid.sv
// Per-frame foreground statistics: pixel count, coordinate sums and bounding box.
// A sequential divider turns the sums into a centroid during blanking.
module blob_centroid #(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int MIN_PIXELS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clk_enable,
  input  logic        frame_enable,
  input  logic [15:0] pixel_color,
  output logic [9:0]  centroid_x,
  output logic [9:0]  centroid_y,
  output logic [9:0]  bbox_x_min,
  output logic [9:0]  bbox_x_max,
  output logic [9:0]  bbox_y_min,
  output logic [9:0]  bbox_y_max,
  output logic [18:0] pixel_count,
  output logic        target_found,
  output logic        result_valid,
  output logic        busy,
  output logic        overrun
);

  localparam logic [2:0]  S_IDLE  = 3'd0;
  localparam logic [2:0]  S_ACCUM = 3'd1;
  localparam logic [2:0]  S_DIV_X = 3'd2;
  localparam logic [2:0]  S_DIV_Y = 3'd3;
  localparam logic [2:0]  S_DONE  = 3'd4;

  localparam logic [9:0]  X_LAST  = 10'(H_ACTIVE - 1);
  localparam logic [9:0]  Y_END   = 10'(V_ACTIVE);
  localparam logic [18:0] MIN_CNT = 19'(MIN_PIXELS);

  logic        r_frame_d;
  logic [2:0]  r_state;
  logic [9:0]  r_x, r_y;
  logic [18:0] r_count;
  logic [27:0] r_sum_x, r_sum_y;
  logic [9:0]  r_x_min, r_x_max, r_y_min, r_y_max;
  logic [18:0] r_rem;
  logic [27:0] r_quo;
  logic [4:0]  r_bit_cnt;
  logic [9:0]  r_qx;

  logic        w_rise, w_fall, w_acc, w_aborting;
  logic [9:0]  w_x_min_base, w_x_max_base, w_y_min_base, w_y_max_base;
  logic [19:0] w_shift, w_diff;
  logic        w_qbit, w_last;
  logic [18:0] w_rem_next;
  logic [27:0] w_quo_next;

  assign w_rise = frame_enable & ~r_frame_d;
  assign w_fall = ~frame_enable & r_frame_d;
  // The first pixel of a frame lands on the same edge that clears the accumulators.
  assign w_acc  = clk_enable & frame_enable & (r_y < Y_END) & (pixel_color != 16'd0) &
                  ((r_state == S_ACCUM) | w_rise);

  assign w_x_min_base = w_rise ? 10'h3FF : r_x_min;
  assign w_x_max_base = w_rise ? 10'h000 : r_x_max;
  assign w_y_min_base = w_rise ? 10'h3FF : r_y_min;
  assign w_y_max_base = w_rise ? 10'h000 : r_y_max;

  // Restoring divide step: bit 19 of the trial difference is the borrow.
  assign w_shift    = {r_rem, r_quo[27]};
  assign w_diff     = w_shift - {1'b0, r_count};
  assign w_qbit     = ~w_diff[19];
  assign w_rem_next = w_qbit ? w_diff[18:0] : w_shift[18:0];
  assign w_quo_next = {r_quo[26:0], w_qbit};
  assign w_last     = (r_bit_cnt == 5'd27);

  assign w_aborting = (r_state == S_DIV_X) | (r_state == S_DIV_Y) | (r_state == S_DONE);
  assign busy       = w_aborting;

  // NOTE: every register uses non-blocking assignment so all state updates see pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_d <= 1'b0;
      r_x       <= '0;
      r_y       <= '0;
    end else begin
      r_frame_d <= frame_enable;
      if (!frame_enable) begin
        r_x <= '0;
        r_y <= '0;
      end else if (clk_enable) begin
        if (r_x == X_LAST) begin
          r_x <= '0;
          if (r_y < Y_END) r_y <= r_y + 10'd1;
        end else begin
          r_x <= r_x + 10'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_sum_x <= '0;
      r_sum_y <= '0;
      r_x_min <= 10'h3FF;
      r_x_max <= '0;
      r_y_min <= 10'h3FF;
      r_y_max <= '0;
    end else if (w_rise || w_acc) begin
      r_count <= (w_rise ? 19'd0 : r_count) + 19'(w_acc);
      r_sum_x <= (w_rise ? 28'd0 : r_sum_x) + (w_acc ? 28'(r_x) : 28'd0);
      r_sum_y <= (w_rise ? 28'd0 : r_sum_y) + (w_acc ? 28'(r_y) : 28'd0);
      r_x_min <= (w_acc && r_x < w_x_min_base) ? r_x : w_x_min_base;
      r_x_max <= (w_acc && r_x > w_x_max_base) ? r_x : w_x_max_base;
      r_y_min <= (w_acc && r_y < w_y_min_base) ? r_y : w_y_min_base;
      r_y_max <= (w_acc && r_y > w_y_max_base) ? r_y : w_y_max_base;
    end
  end

  // NOTE: divider datapath registers are reset too, so a reset mid-divide leaves no stale quotient.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_rem        <= '0;
      r_quo        <= '0;
      r_bit_cnt    <= '0;
      r_qx         <= '0;
      centroid_x   <= '0;
      centroid_y   <= '0;
      bbox_x_min   <= 10'h3FF;
      bbox_x_max   <= '0;
      bbox_y_min   <= 10'h3FF;
      bbox_y_max   <= '0;
      pixel_count  <= '0;
      target_found <= 1'b0;
      result_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      overrun      <= 1'b0;
      if (w_rise) begin
        overrun <= w_aborting;
        r_state <= S_ACCUM;
      end else begin
        case (r_state)
          S_ACCUM: begin
            if (w_fall) begin
              if (r_count == 19'd0) begin
                r_state <= S_DONE;
              end else begin
                r_state   <= S_DIV_X;
                r_rem     <= '0;
                r_quo     <= r_sum_x;
                r_bit_cnt <= '0;
              end
            end
          end
          S_DIV_X: begin
            r_rem     <= w_rem_next;
            r_quo     <= w_quo_next;
            r_bit_cnt <= r_bit_cnt + 5'd1;
            if (w_last) begin
              r_qx      <= w_quo_next[9:0];
              r_rem     <= '0;
              r_quo     <= r_sum_y;
              r_bit_cnt <= '0;
              r_state   <= S_DIV_Y;
            end
          end
          S_DIV_Y: begin
            r_rem     <= w_rem_next;
            r_quo     <= w_quo_next;
            r_bit_cnt <= r_bit_cnt + 5'd1;
            if (w_last) r_state <= S_DONE;
          end
          S_DONE: begin
            pixel_count  <= r_count;
            bbox_x_min   <= r_x_min;
            bbox_x_max   <= r_x_max;
            bbox_y_min   <= r_y_min;
            bbox_y_max   <= r_y_max;
            target_found <= (r_count >= MIN_CNT);
            if (r_count != 19'd0) begin
              centroid_x <= r_qx;
              centroid_y <= r_quo[9:0];
            end
            result_valid <= 1'b1;
            r_state      <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_blob_centroid.sv
// Randomized scoreboard bench for blob_centroid on a reduced 128x64 raster.
// Expected results come from a plain-arithmetic frame model; a monitor checks each result pulse.
module tb_blob_centroid;

  localparam int H    = 128;
  localparam int V    = 64;
  localparam int MINP = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clk_enable = 1'b0;
  logic        frame_enable = 1'b0;
  logic [15:0] pixel_color = 16'd0;
  logic [9:0]  centroid_x, centroid_y, bbox_x_min, bbox_x_max, bbox_y_min, bbox_y_max;
  logic [18:0] pixel_count;
  logic        target_found, result_valid, busy, overrun;

  blob_centroid #(.H_ACTIVE(H), .V_ACTIVE(V), .MIN_PIXELS(MINP)) dut (
    .clk(clk), .rst_n(rst_n), .clk_enable(clk_enable), .frame_enable(frame_enable),
    .pixel_color(pixel_color), .centroid_x(centroid_x), .centroid_y(centroid_y),
    .bbox_x_min(bbox_x_min), .bbox_x_max(bbox_x_max), .bbox_y_min(bbox_y_min),
    .bbox_y_max(bbox_y_max), .pixel_count(pixel_count), .target_found(target_found),
    .result_valid(result_valid), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cx, cy, xmin, xmax, ymin, ymax, cnt, found;
    int unsigned cyc;
  } res_t;

  localparam res_t RESET_RES = '{0, 0, 1023, 0, 1023, 0, 0, 0, 0};

  res_t sb[$];
  res_t last = RESET_RES;
  res_t mon_e;
  int   n_pass = 0, n_total = 0, exp_ovr = 0, seen_ovr = 0;
  int   m_cx = 0, m_cy = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [15:0] pix(input int mode, input int idx, input int k);
    int x, y;
    x = idx % H;
    y = idx / H;
    case (mode)
      0: return (x == 100 && y == 50) ? 16'h8000 : 16'h0000;
      1: return (x >= 100 && x <= 109 && y >= 40 && y <= 49) ? 16'hFFFF : 16'h0000;
      2: return 16'h0000;
      3: return 16'hFFFF;
      4: return ($urandom_range(0, 3) == 0) ? 16'($urandom_range(1, 65535)) : 16'h0000;
      default: return (idx < k) ? 16'h0001 : 16'h0000;
    endcase
  endfunction

  // One frame of n_beats enabled pixels with random idle gaps; pushes the expected result.
  task automatic send_frame(input int mode, input int n_beats, input int k, input bit abort);
    int cnt, xmin, xmax, ymin, ymax, x, y;
    longint sx, sy;
    logic [15:0] p;
    res_t e;
    cnt = 0; sx = 0; sy = 0; xmin = 1023; xmax = 0; ymin = 1023; ymax = 0;
    for (int i = 0; i < n_beats; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        repeat ($urandom_range(1, 3)) begin
          @(negedge clk);
          frame_enable = 1'b1;
          clk_enable   = 1'b0;
          pixel_color  = 16'($urandom);
        end
      end
      @(negedge clk);
      p = pix(mode, i, k);
      frame_enable = 1'b1;
      clk_enable   = 1'b1;
      pixel_color  = p;
      x = i % H;
      y = i / H;
      if (y < V && p != 16'd0) begin
        cnt++;
        sx += x;
        sy += y;
        if (x < xmin) xmin = x;
        if (x > xmax) xmax = x;
        if (y < ymin) ymin = y;
        if (y > ymax) ymax = y;
      end
    end
    @(negedge clk);
    frame_enable = 1'b0;
    clk_enable   = 1'b0;
    pixel_color  = 16'd0;
    if (!abort) begin
      if (cnt > 0) begin
        m_cx = int'(sx / cnt);
        m_cy = int'(sy / cnt);
      end
      e.cx = m_cx; e.cy = m_cy;
      e.xmin = xmin; e.xmax = xmax; e.ymin = ymin; e.ymax = ymax;
      e.cnt = cnt;
      e.found = (cnt >= MINP) ? 1 : 0;
      e.cyc = cyc + 1 + ((cnt > 0) ? 57 : 1);
      sb.push_back(e);
    end
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      n_total++;
      $display("FAIL result_timeout: %0d results still pending, expected 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (result_valid) begin
        if (sb.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_result_valid: got 1 expected 0 (cycle %0d)", cyc);
        end else begin
          mon_e = sb.pop_front();
          check("latency", cyc, mon_e.cyc);
          check("centroid_x", centroid_x, mon_e.cx);
          check("centroid_y", centroid_y, mon_e.cy);
          check("bbox_x_min", bbox_x_min, mon_e.xmin);
          check("bbox_x_max", bbox_x_max, mon_e.xmax);
          check("bbox_y_min", bbox_y_min, mon_e.ymin);
          check("bbox_y_max", bbox_y_max, mon_e.ymax);
          check("pixel_count", pixel_count, mon_e.cnt);
          check("target_found", target_found, mon_e.found);
          last = mon_e;
        end
      end
      if (overrun) begin
        seen_ovr++;
        check("overrun_hold_cx", centroid_x, last.cx);
        check("overrun_hold_cy", centroid_y, last.cy);
        check("overrun_hold_count", pixel_count, last.cnt);
        check("overrun_no_valid", result_valid, 0);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("reset_centroid_x", centroid_x, 0);
    check("reset_bbox_x_min", bbox_x_min, 1023);
    check("reset_bbox_y_min", bbox_y_min, 1023);
    check("reset_pixel_count", pixel_count, 0);
    check("reset_result_valid", result_valid, 0);
    check("reset_busy", busy, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    send_frame(0, 50 * H + 101, 0, 1'b0);
    repeat (5) @(negedge clk);
    check("busy_during_divide", busy, 1);
    wait_idle();

    send_frame(1, 49 * H + 110, 0, 1'b0);
    wait_idle();

    send_frame(2, 300, 0, 1'b0);
    wait_idle();

    send_frame(5, 20, MINP - 1, 1'b0);
    wait_idle();
    send_frame(5, 20, MINP, 1'b0);
    wait_idle();

    send_frame(3, H * V + 40, 0, 1'b0);
    wait_idle();

    send_frame(4, 500, 0, 1'b1);
    exp_ovr++;
    repeat (19) @(negedge clk);
    send_frame(4, 600, 0, 1'b0);
    wait_idle();

    for (int f = 0; f < 4; f++) begin
      send_frame(4, int'($urandom_range(1, 3000)), 0, 1'b0);
      wait_idle();
    end

    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      frame_enable = 1'b1;
      clk_enable   = 1'b1;
      pixel_color  = 16'hFFFF;
    end
    @(negedge clk);
    rst_n        = 1'b0;
    frame_enable = 1'b0;
    clk_enable   = 1'b0;
    pixel_color  = 16'd0;
    @(negedge clk);
    check("midreset_centroid_x", centroid_x, 0);
    check("midreset_bbox_x_min", bbox_x_min, 1023);
    check("midreset_pixel_count", pixel_count, 0);
    check("midreset_target_found", target_found, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_cx  = 0;
    m_cy  = 0;
    last  = RESET_RES;
    send_frame(5, 10, 4, 1'b0);
    wait_idle();

    check("overrun_count", seen_ovr, exp_ovr);
    check("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
